// File: rtl/fmul.sv
// Two-stage bfloat16 x bfloat16 multiplier with an exact binary32 product, flush-to-zero output.
// Define FMUL_SUBNORMAL_EN to normalize subnormal operands instead of treating them as zero.
module fmul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [31:0] mul_out
);

  localparam logic [31:0] QuietNan = 32'h7FC0_0000;

  logic [7:0] a_exp, b_exp;
  logic [6:0] a_frac, b_frac;
  logic       a_exp_zero, b_exp_zero, a_exp_max, b_exp_max;
  logic       a_frac_zero, b_frac_zero;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [7:0] a_sig, b_sig;
  logic signed [9:0] a_eff, b_eff;

  assign a_exp       = a[14:7];
  assign b_exp       = b[14:7];
  assign a_frac      = a[6:0];
  assign b_frac      = b[6:0];
  assign a_exp_zero  = (a_exp == 8'd0);
  assign b_exp_zero  = (b_exp == 8'd0);
  assign a_exp_max   = (a_exp == 8'hFF);
  assign b_exp_max   = (b_exp == 8'hFF);
  assign a_frac_zero = (a_frac == 7'd0);
  assign b_frac_zero = (b_frac == 7'd0);
  assign a_nan       = a_exp_max & ~a_frac_zero;
  assign b_nan       = b_exp_max & ~b_frac_zero;
  assign a_inf       = a_exp_max & a_frac_zero;
  assign b_inf       = b_exp_max & b_frac_zero;

`ifdef FMUL_SUBNORMAL_EN
  function automatic logic [2:0] lzc7(input logic [6:0] f);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (f[i]) cnt = 3'(6 - i);
    end
    return cnt;
  endfunction

  logic [2:0] a_lz, b_lz, a_shamt, b_shamt;

  assign a_zero  = a_exp_zero & a_frac_zero;
  assign b_zero  = b_exp_zero & b_frac_zero;
  assign a_lz    = lzc7(a_frac);
  assign b_lz    = lzc7(b_frac);
  // Shift past the leading one so it lands in the implicit-bit position.
  assign a_shamt = a_lz + 3'd1;
  assign b_shamt = b_lz + 3'd1;

  always_comb begin
    a_sig = {1'b1, a_frac};
    b_sig = {1'b1, b_frac};
    a_eff = $signed({2'b00, a_exp});
    b_eff = $signed({2'b00, b_exp});
    if (a_exp_zero) begin
      a_sig = {1'b0, a_frac} << a_shamt;
      a_eff = 10'sd1 - $signed({7'b0, a_shamt});
    end
    if (b_exp_zero) begin
      b_sig = {1'b0, b_frac} << b_shamt;
      b_eff = 10'sd1 - $signed({7'b0, b_shamt});
    end
  end
`else
  assign a_zero = a_exp_zero;
  assign b_zero = b_exp_zero;
  assign a_sig  = {1'b1, a_frac};
  assign b_sig  = {1'b1, b_frac};
  assign a_eff  = $signed({2'b00, a_exp});
  assign b_eff  = $signed({2'b00, b_exp});
`endif

  // Stage 1: classification, sign, exponent sum, significand product
  logic              s1_valid_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
  logic signed [9:0] s1_exp_q;
  logic [15:0]       s1_prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_prod_q  <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= a[15] ^ b[15];
        s1_nan_q  <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
        s1_inf_q  <= a_inf | b_inf;
        s1_zero_q <= a_zero | b_zero;
        s1_exp_q  <= a_eff + b_eff - 10'sd127;
        s1_prod_q <= {8'b0, a_sig} * {8'b0, b_sig};
      end
    end
  end

  // Stage 2: normalization and special-case selection
  logic signed [9:0] e_norm;
  logic [22:0]       frac_norm;
  logic [31:0]       result;

  always_comb begin
    if (s1_prod_q[15]) begin
      e_norm    = s1_exp_q + 10'sd1;
      frac_norm = {s1_prod_q[14:0], 8'b0};
    end else begin
      e_norm    = s1_exp_q;
      frac_norm = {s1_prod_q[13:0], 9'b0};
    end

    if (s1_nan_q) begin
      result = QuietNan;
    end else if (s1_inf_q || (!s1_zero_q && e_norm >= 10'sd255)) begin
      result = {s1_sign_q, 8'hFF, 23'b0};
    end else if (s1_zero_q || e_norm <= 10'sd0) begin
      result = {s1_sign_q, 31'b0};
    end else begin
      result = {s1_sign_q, e_norm[7:0], frac_norm};
    end
  end

  logic        out_valid_q;
  logic [31:0] mul_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      mul_out_q   <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) mul_out_q <= result;
    end
  end

  assign out_valid = out_valid_q;
  assign mul_out   = mul_out_q;

endmodule

// File: tb/tb_fmul.sv
// Randomized self-checking bench for fmul against a value-level exact-product model.
module tb_fmul;

`ifdef FMUL_SUBNORMAL_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a, b;
  logic        out_valid;
  logic [31:0] mul_out;

  fmul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .mul_out   (mul_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int last_rst = -1000;
  logic [31:0] last_out = '0;
  bit          issued [8192];
  logic [31:0] res    [8192];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%08h expected=%08h", tag, cycle, got, want);
    end
  endtask

  // Value model: operand = m * 2^e, product taken exactly, then re-encoded into binary32.
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    int     ex, ey, e, k, be;
    longint mx, my, m, fr;
    bit     nx, ny, ix, iy, zx, zy, s;
    s  = x[15] ^ y[15];
    nx = (x[14:7] == 8'hFF) && (x[6:0] != 0);
    ny = (y[14:7] == 8'hFF) && (y[6:0] != 0);
    ix = (x[14:7] == 8'hFF) && (x[6:0] == 0);
    iy = (y[14:7] == 8'hFF) && (y[6:0] == 0);
    zx = (x[14:7] == 0) && ((x[6:0] == 0) || !SubEn);
    zy = (y[14:7] == 0) && ((y[6:0] == 0) || !SubEn);
    if (nx || ny || (ix && zy) || (zx && iy)) return 32'h7FC0_0000;
    if (ix || iy) return {s, 8'hFF, 23'b0};
    if (zx || zy) return {s, 31'b0};
    if (x[14:7] == 0) begin mx = longint'(x[6:0]); ex = -133; end
    else begin mx = 128 + longint'(x[6:0]); ex = int'(x[14:7]) - 134; end
    if (y[14:7] == 0) begin my = longint'(y[6:0]); ey = -133; end
    else begin my = 128 + longint'(y[6:0]); ey = int'(y[14:7]) - 134; end
    m = mx * my;
    e = ex + ey;
    k = 0;
    for (int i = 0; i < 16; i++) if (m >= (longint'(1) << i)) k = i;
    be = e + k + 127;
    if (be >= 255) return {s, 8'hFF, 23'b0};
    if (be <= 0) return {s, 31'b0};
    fr = (m << (23 - k)) & 64'h7F_FFFF;
    return {s, be[7:0], fr[22:0]};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [7:0] e;
    logic [6:0] f;
    int sel;
    sel = $urandom_range(0, 9);
    f   = 7'($urandom);
    if ($urandom_range(0, 5) == 0) f = 7'd0;
    case (sel)
      0:       e = 8'd0;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 4));
      3:       e = 8'($urandom_range(250, 254));
      4:       e = 8'($urandom_range(60, 70));
      5:       e = 8'($urandom_range(185, 195));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic [31:0] want);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = x;
    b = y;
    issued[cycle] = 1'b1;
    res[cycle] = want;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
    end
  endtask

  // Ops whose window overlaps a reset are discarded by the design.
  int idx;
  bit ev;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_rst = cycle;
      last_out = '0;
    end else if (cycle >= 2) begin
      idx = cycle - 2;
      ev  = issued[idx] && (idx > last_rst);
      check("out_valid", {31'b0, out_valid}, {31'b0, ev});
      if (ev) begin
        check("mul_out", mul_out, res[idx]);
        last_out = res[idx];
      end else begin
        check("hold", mul_out, last_out);
      end
    end
  end

  initial begin
    logic [15:0] x, y;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out", mul_out, 32'd0);
    #2 rst_n = 1'b1;

    idle(2);
    drive(16'h3FC0, 16'h3FC0, 32'h4010_0000);
    idle(3);
    drive(16'h4000, 16'hC040, 32'hC0C0_0000);
    drive(16'h3F80, 16'h3F80, 32'h3F80_0000);
    drive(16'h7F7F, 16'h7F7F, 32'h7F80_0000);
    drive(16'h0080, 16'h3F00, 32'h0000_0000);
    drive(16'h8080, 16'h3F00, 32'h8000_0000);
    drive(16'h7F80, 16'h0000, 32'h7FC0_0000);
    drive(16'hFF80, 16'h3F80, 32'hFF80_0000);
    drive(16'h7FC1, 16'h3F80, 32'h7FC0_0000);
    drive(16'h0001, 16'h5F80, SubEn ? 32'h1D00_0000 : 32'h0000_0000);
    drive(16'h7F80, 16'h0001, SubEn ? 32'h7F80_0000 : 32'h7FC0_0000);
    drive(16'h8000, 16'h4000, 32'h8000_0000);
    idle(4);

    // Reset with two operations in flight
    drive(16'h3FC0, 16'h4000, 32'h4040_0000);
    drive(16'h4040, 16'h4040, 32'h4110_0000);
    #2 rst_n = 1'b0;
    #1;
    check("rst_flight_valid", {31'b0, out_valid}, 32'd0);
    check("rst_flight_out", mul_out, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(5);

    for (int i = 0; i < 2000; i++) begin
      x = rand_op();
      y = rand_op();
      if ($urandom_range(0, 4) == 0) idle(1);
      else drive(x, y, ref_mul(x, y));
    end
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
